// File: rtl/wino_tile_conv.sv
// wino_tile_conv: 3-tap 1-D tile convolution, one multiply per cycle.
// Captures an N-sample tile, emits M outputs with optional saturation.
module wino_tile_conv #(
    parameter int DW  = 10,
    parameter int M   = 7,
    parameter bit SAT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [(M+2)*DW-1:0]   D,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  coef_we,
    input  logic [3*DW-1:0]       coef,
    output logic [M*DW-1:0]       Z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  ovf
);
    localparam int N  = M + 2;
    localparam int AW = 2 * DW + 2;
    localparam int IW = $clog2(N);

    localparam logic signed [AW-1:0] MAXV =
        {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV =
        {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                 st;
    logic signed [DW-1:0]   dr  [N];
    logic signed [DW-1:0]   g   [3];
    logic signed [DW-1:0]   res [N];
    logic [IW-1:0]          idx;
    logic [IW-1:0]          tap;
    logic signed [AW-1:0]   acc;
    logic                   ovf_acc;

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   sum;
    logic                   sum_ovf;
    logic signed [DW-1:0]   fin;

    always_comb begin
        prod    = dr[idx + tap] * g[tap[1:0]];
        sum     = acc + AW'(prod);
        sum_ovf = (sum > MAXV) || (sum < MINV);
        fin     = sum[DW-1:0];
        if (SAT) begin
            if (sum > MAXV)
                fin = MAXV[DW-1:0];
            else if (sum < MINV)
                fin = MINV[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Z         <= '0;
            ovf       <= 1'b0;
            ovf_acc   <= 1'b0;
            acc       <= '0;
            idx       <= '0;
            tap       <= '0;
            for (int i = 0; i < 3; i++) g[i] <= '0;
            for (int i = 0; i < N; i++) begin
                dr[i]  <= '0;
                res[i] <= '0;
            end
        end else begin
            unique case (st)
                IDLE: begin
                    if (coef_we)
                        for (int k = 0; k < 3; k++)
                            g[k] <= coef[(2-k)*DW +: DW];
                    if (in_valid) begin
                        for (int i = 0; i < N; i++)
                            dr[i] <= D[(N-1-i)*DW +: DW];
                        acc      <= '0;
                        idx      <= '0;
                        tap      <= '0;
                        ovf_acc  <= 1'b0;
                        in_ready <= 1'b0;
                        st       <= CALC;
                    end
                end
                CALC: begin
                    if (tap == IW'(2)) begin
                        acc      <= '0;
                        tap      <= '0;
                        res[idx] <= fin;
                        ovf_acc  <= ovf_acc | sum_ovf;
                        if (idx == IW'(M-1)) begin
                            // last output closes the tile: publish all at once
                            idx       <= '0;
                            ovf       <= ovf_acc | sum_ovf;
                            out_valid <= 1'b1;
                            st        <= DONE;
                            for (int i = 0; i < M; i++)
                                Z[(M-1-i)*DW +: DW] <=
                                    (i == M-1) ? fin : res[i];
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        acc <= sum;
                        tap <= tap + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        st        <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wino_tile_conv.sv
// Bench for wino_tile_conv: wrap and saturate instances side by side,
// fixed vector table, hand sequences and random tiles against a model.
module tb_wino_tile_conv;
    localparam int DW = 10;
    localparam int M  = 7;
    localparam int N  = M + 2;
    localparam int LAT = 3 * M + 1;

    typedef struct packed {
        logic [2:0][DW-1:0]   g;
        logic [N-1:0][DW-1:0] d;
        logic [M-1:0][DW-1:0] zw;
        logic [M-1:0][DW-1:0] zs;
        logic                 ov;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*DW-1:0]   D = '0;
    logic              in_valid = 1'b0;
    logic              coef_we = 1'b0;
    logic [3*DW-1:0]   coef = '0;
    logic              out_ready = 1'b0;

    logic              rdy_w, rdy_s, ov_w, ov_s, vld_w, vld_s;
    logic [M*DW-1:0]   z_w, z_s;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int tcap = 0;

    logic [2:0][DW-1:0]   model_g;
    logic [N-1:0][DW-1:0] model_d;
    vec_t                 tbl [3];

    wino_tile_conv #(.DW(DW), .M(M), .SAT(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .D(D), .in_valid(in_valid),
        .in_ready(rdy_w), .coef_we(coef_we), .coef(coef),
        .Z(z_w), .out_valid(vld_w), .out_ready(out_ready), .ovf(ov_w)
    );

    wino_tile_conv #(.DW(DW), .M(M), .SAT(1'b1)) u_sat (
        .clk(clk), .rst(rst), .D(D), .in_valid(in_valid),
        .in_ready(rdy_s), .coef_we(coef_we), .coef(coef),
        .Z(z_s), .out_valid(vld_s), .out_ready(out_ready), .ovf(ov_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N*DW-1:0] pack_d(
        input logic [N-1:0][DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[(N-1-i)*DW +: DW] = v[i];
        return r;
    endfunction

    function automatic logic [M*DW-1:0] pack_z(
        input logic [M-1:0][DW-1:0] v);
        logic [M*DW-1:0] r;
        for (int i = 0; i < M; i++) r[(M-1-i)*DW +: DW] = v[i];
        return r;
    endfunction

    function automatic logic [3*DW-1:0] pack_g(
        input logic [2:0][DW-1:0] v);
        return {v[0], v[1], v[2]};
    endfunction

    function automatic logic [N*DW-1:0] junk();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[N*DW-1:0];
    endfunction

    // Plain arithmetic reference: sum of products, then wrap or clamp.
    task automatic model(output logic [M*DW-1:0] zw,
                         output logic [M*DW-1:0] zs, output logic ov);
        longint s;
        longint hi;
        longint lo;
        hi = (longint'(1) << (DW-1)) - 1;
        lo = -(longint'(1) << (DW-1));
        ov = 1'b0;
        for (int i = 0; i < M; i++) begin
            s = 0;
            for (int k = 0; k < 3; k++)
                s += longint'($signed(model_d[i+k])) *
                     longint'($signed(model_g[k]));
            if (s > hi || s < lo) ov = 1'b1;
            zw[(M-1-i)*DW +: DW] = s[DW-1:0];
            if (s > hi)
                zs[(M-1-i)*DW +: DW] = hi[DW-1:0];
            else if (s < lo)
                zs[(M-1-i)*DW +: DW] = lo[DW-1:0];
            else
                zs[(M-1-i)*DW +: DW] = s[DW-1:0];
        end
    endtask

    task automatic write_coef(input logic [2:0][DW-1:0] gv);
        @(negedge clk);
        coef    = pack_g(gv);
        coef_we = 1'b1;
        @(negedge clk);
        coef_we = 1'b0;
        model_g = gv;
    endtask

    task automatic send_tile(input logic [N-1:0][DW-1:0] dv,
                             input bit wr, input logic [2:0][DW-1:0] gv);
        @(negedge clk);
        chk("in_ready_idle", {rdy_w, rdy_s}, 2'b11);
        D        = pack_d(dv);
        in_valid = 1'b1;
        if (wr) begin
            coef    = pack_g(gv);
            coef_we = 1'b1;
            model_g = gv;
        end
        model_d = dv;
        tcap    = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        coef_we  = 1'b0;
        D        = junk();
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!vld_w && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_seen", {vld_w, vld_s}, 2'b11);
        chk("latency", 128'(cyc - tcap), 128'(LAT));
    endtask

    task automatic check_out(input string nm, input logic [M*DW-1:0] ew,
                             input logic [M*DW-1:0] es, input logic eo);
        chk({nm, "_z_wrap"}, z_w, ew);
        chk({nm, "_z_sat"}, z_s, es);
        chk({nm, "_ovf"}, {ov_w, ov_s}, {eo, eo});
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {vld_w, vld_s}, 2'b00);
        chk("in_ready_back", {rdy_w, rdy_s}, 2'b11);
    endtask

    initial begin
        logic [M*DW-1:0]      ew, es;
        logic                 eo;
        logic [2:0][DW-1:0]   gv, g9;
        logic [N-1:0][DW-1:0] dv;

        for (int k = 0; k < 3; k++) begin
            tbl[0].g[k] = DW'(k + 1);
            tbl[1].g[k] = DW'(511);
            g9[k]       = DW'(9);
        end
        tbl[2].g[0] = DW'(-1);
        tbl[2].g[1] = DW'(0);
        tbl[2].g[2] = DW'(2);
        for (int i = 0; i < N; i++) begin
            tbl[0].d[i] = DW'(i + 1);
            tbl[1].d[i] = DW'(511);
            tbl[2].d[i] = DW'(i - 10);
        end
        for (int i = 0; i < M; i++) begin
            tbl[0].zw[i] = DW'(14 + 6 * i);
            tbl[0].zs[i] = DW'(14 + 6 * i);
            tbl[1].zw[i] = DW'(3);
            tbl[1].zs[i] = DW'(511);
            tbl[2].zw[i] = DW'(i - 6);
            tbl[2].zs[i] = DW'(i - 6);
        end
        tbl[0].ov = 1'b0;
        tbl[1].ov = 1'b1;
        tbl[2].ov = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", {rdy_w, rdy_s}, 2'b11);
        chk("rst_out_valid", {vld_w, vld_s}, 2'b00);
        chk("rst_z", {z_w, z_s}, '0);
        chk("rst_ovf", {ov_w, ov_s}, 2'b00);
        rst = 1'b1;

        for (int t = 0; t < 3; t++) begin
            write_coef(tbl[t].g);
            send_tile(tbl[t].d, 1'b0, tbl[t].g);
            wait_out();
            check_out($sformatf("table%0d", t), pack_z(tbl[t].zw),
                      pack_z(tbl[t].zs), tbl[t].ov);
            release_out();
        end

        // backpressure with a competing tile offered while DONE
        write_coef(tbl[0].g);
        for (int i = 0; i < N; i++)
            dv[i] = DW'($urandom_range(0, 1023));
        send_tile(dv, 1'b0, tbl[0].g);
        model(ew, es, eo);
        wait_out();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            D        = junk();
            @(negedge clk);
            check_out("bp", ew, es, eo);
            chk("bp_in_ready", {rdy_w, rdy_s}, 2'b00);
            chk("bp_out_valid", {vld_w, vld_s}, 2'b11);
        end
        in_valid = 1'b0;
        release_out();

        // coefficient writes during CALC must be ignored
        send_tile(tbl[0].d, 1'b0, tbl[0].g);
        repeat (3) @(negedge clk);
        coef    = pack_g(g9);
        coef_we = 1'b1;
        repeat (2) @(negedge clk);
        coef_we = 1'b0;
        wait_out();
        check_out("coefprot1", pack_z(tbl[0].zw), pack_z(tbl[0].zs), 1'b0);
        release_out();
        send_tile(tbl[0].d, 1'b0, tbl[0].g);
        wait_out();
        check_out("coefprot2", pack_z(tbl[0].zw), pack_z(tbl[0].zs), 1'b0);
        release_out();

        // reset on the 10th CALC cycle
        send_tile(tbl[0].d, 1'b0, tbl[0].g);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", {vld_w, vld_s}, 2'b00);
        chk("midrst_z", {z_w, z_s}, '0);
        @(negedge clk);
        rst = 1'b1;
        model_g = '0;
        @(negedge clk);
        chk("midrst_in_ready", {rdy_w, rdy_s}, 2'b11);
        send_tile(tbl[0].d, 1'b0, tbl[0].g);
        model(ew, es, eo);
        wait_out();
        check_out("after_rst", ew, es, eo);
        chk("after_rst_zero", z_w, '0);
        release_out();

        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < 3; k++)
                gv[k] = (r % 2 == 0) ? DW'($urandom_range(0, 1023))
                                     : DW'(int'($urandom_range(0, 40)) - 20);
            for (int i = 0; i < N; i++)
                dv[i] = (r % 2 == 0) ? DW'($urandom_range(0, 1023))
                                     : DW'(int'($urandom_range(0, 40)) - 20);
            if (r % 4 < 2) begin
                send_tile(dv, 1'b1, gv);
            end else begin
                write_coef(gv);
                send_tile(dv, 1'b0, gv);
            end
            model(ew, es, eo);
            wait_out();
            check_out($sformatf("rand%0d", r), ew, es, eo);
            release_out();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wino_tile_conv.md
WINO_TILE_CONV -- requirements
Module: wino_tile_conv

Interface
REQ-001 SHALL have parameter DW, default 10, meaning signed two's-complement width of samples, coefficients and results.
REQ-002 SHALL have parameter M, default 7, meaning outputs per tile; the tile holds N = M+2 input samples; the filter has 3 taps.
REQ-003 SHALL have parameter SAT, default 0, meaning 0 = wrap results to DW bits, 1 = saturate results to DW bits.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port D, input, N*DW bits, the input tile; element 0 occupies the MSB field, element N-1 the LSB field.
REQ-007 SHALL have port in_valid, input, 1 bit, meaning D is presented.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts a tile.
REQ-009 SHALL have port coef_we, input, 1 bit, the coefficient write strobe.
REQ-010 SHALL have port coef, input, 3*DW bits, holding G[0] in the MSB field and G[2] in the LSB field.
REQ-011 SHALL have port Z, output, M*DW bits, the result tile; element 0 occupies the MSB field.
REQ-012 SHALL have port out_valid, output, 1 bit, meaning Z is valid.
REQ-013 SHALL have port out_ready, input, 1 bit, meaning downstream accepts Z.
REQ-014 SHALL have port ovf, output, 1 bit, meaning at least one result of the current tile exceeded the DW range.

Function
REQ-015 SHALL compute Z[i] = sum over k=0..2 of D[i+k]*G[k], for i = 0..M-1, as signed arithmetic.
REQ-016 SHALL accumulate at a width of at least 2*DW+2 bits, with no intermediate truncation.
REQ-017 SHALL form the final result as follows: SAT=0 takes the low DW bits of the sum; SAT=1 clamps the sum to [-2^(DW-1), 2^(DW-1)-1].
REQ-018 SHALL set ovf when any sum in the tile lies outside [-2^(DW-1), 2^(DW-1)-1], in both modes; ovf is held with out_valid.
REQ-019 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-020 SHALL assert in_ready only in IDLE; on in_valid && in_ready, D is captured into an internal register and the FSM moves to CALC.
REQ-021 SHALL use a single multiplier in CALC, one tap per cycle, with tap and output counters; CALC lasts exactly 3*M cycles, then the FSM moves to DONE.
REQ-022 SHALL define latency as follows: with the capture edge at cycle T, out_valid rises at cycle T+3M+1 (T+22 for M=7).
REQ-023 SHALL, in DONE, hold Z, ovf and out_valid stable until out_ready is high; on that edge out_valid drops, the FSM returns to IDLE, and in_ready is 1 the next cycle.
REQ-024 SHALL accept coef_we only in IDLE, including the capture cycle; a write in the capture cycle applies to that tile.
REQ-025 SHALL ignore coef_we in CALC and DONE; the coefficients remain unchanged.
REQ-026 SHALL leave D unsampled outside the capture edge; changes on D during CALC/DONE do not affect the result.
REQ-027 SHALL NOT accept overlapping tiles; in_valid in CALC/DONE is ignored and no state changes.

Reset
REQ-028 SHALL, when rst is low at any time, immediately and asynchronously set: FSM to IDLE, in_ready=1 after release, out_valid=0, Z=0, ovf=0, G[0..2]=0, and clear all counters and accumulators.
REQ-029 SHALL discard a tile in progress on reset; no partial Z is ever presented.
REQ-030 SHALL deassert rst synchronously to clk in the bench, with the first capture possible on the first edge after release.

Verification
REQ-031 SHALL cover the basic case: DW=10, M=7, G=[1,2,3] written in IDLE, D=[1..9] -> Z=[14,20,26,32,38,44,50], ovf=0, out_valid exactly 22 cycles after capture.
REQ-032 SHALL cover overflow: G=[511,511,511], D all 511 -> SAT=0 gives all Z=3 with ovf=1; SAT=1 gives all Z=511 with ovf=1.
REQ-033 SHALL cover negative values: G=[-1,0,2], D=[-10,-9,...,-2] -> Z=[-6,-5,-4,-3,-2,-1,0], ovf=0.
REQ-034 SHALL cover backpressure: out_ready held low 5 cycles after out_valid -> Z and ovf stable, in_ready=0, and a new in_valid tile is not captured; after the out_ready handshake, in_ready=1 the next cycle.
REQ-035 SHALL cover coefficient protection: coef_we with G=[9,9,9] during CALC -> current and next tile still use G=[1,2,3].
REQ-036 SHALL cover reset mid-operation: rst low on the 10th CALC cycle -> out_valid=0 and Z=0 immediately; after release, in_ready=1; the next tile, with no coef write, gives Z all 0.
